// File: rtl/pll_loop_ctrl.sv
// pll_loop_ctrl: ADPLL loop controller.
// The FLL integrates freq_err until the frequency is settled, then the TDC phase loop (PI) takes over.
// Lock detect promotes to PHASE_LOCKED and demotes on sustained phase error or a frequency jump.
// A rising edge on brake pulls dctrl down by BRAKE_CODE, holds it for BRAKE_CYCLES, then ramps it back up.
// Optional build macro PLL_LF_GEARSHIFT_EN: after 32 cycles in PHASE_LOCKED the phase-loop gains are quartered.
module pll_loop_ctrl #(
  parameter int CNT_W        = 12,
  parameter int TDC_W        = 10,
  parameter int DW           = 24,
  parameter int KI_FREQ      = 400,
  parameter int KP_PHASE     = 10,
  parameter int KI_PHASE     = 1,
  parameter int FLOCK_CYCLES = 10,
  parameter int PLOCK_CYCLES = 16,
  parameter int PLOCK_TOL    = 1,
  parameter int ULOCK_TOL    = 64,
  parameter int ULOCK_CYCLES = 4,
  parameter int BRAKE_CODE   = 200000,
  parameter int BRAKE_CYCLES = 100,
  parameter int BRAKE_STEP   = 2000
) (
  input  logic                    refclk,
  input  logic                    reset,
  input  logic [CNT_W-1:0]        divn,
  input  logic [CNT_W-1:0]        fmeas,
  input  logic                    fmeas_vld,
  input  logic signed [TDC_W-1:0] tdc_out,
  input  logic                    tdc_vld,
  input  logic                    brake,
  output logic signed [DW-1:0]    dctrl,
  output logic [2:0]              lock_state,
  output logic                    locked
);

  localparam int ACC_W = DW;
  localparam int AW1   = ACC_W + 1;
  localparam int WW    = DW + 32;
  localparam int CW    = $clog2(BRAKE_CYCLES + FLOCK_CYCLES + PLOCK_CYCLES + ULOCK_CYCLES + 1);
  localparam logic signed [TDC_W-1:0] TDC_MAX = {1'b0, {(TDC_W-1){1'b1}}};

  typedef enum logic [2:0] {
    S_UNLOCKED = 3'd0,
    S_FLOCK    = 3'd1,
    S_PLOCK    = 3'd2,
    S_BRAKING  = 3'd3,
    S_RECOV    = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_f_q, acc_f_d, acc_p_q, acc_p_d;
  logic signed [DW-1:0]    brake_off_q, brake_off_d, dctrl_q, dctrl_d;
  logic [CW-1:0]           fcnt_q, fcnt_d, pcnt_q, pcnt_d, ucnt_q, ucnt_d, bcnt_q, bcnt_d;
  logic                    brake_q;

  logic signed [CNT_W:0]   freq_err;
  logic signed [TDC_W-1:0] phase_raw, phase_eff;
  logic                    brake_edge, fe_zero, fe_big, pe_small, pe_big;
  logic signed [WW-1:0]    term_f, term_p, term_kp;

  // Clamp a one-bit-wider sum back into the accumulator range instead of wrapping.
  function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [AW1-1:0] s);
    if (s[AW1-1] != s[AW1-2])
      return s[AW1-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    return s[ACC_W-1:0];
  endfunction

  // Clamp the wide control sum into the signed DCO code range.
  function automatic logic signed [DW-1:0] sat_dw(input logic signed [WW-1:0] v);
    if (!v[WW-1] && (|v[WW-2:DW-1])) return {1'b0, {(DW-1){1'b1}}};
    if (v[WW-1] && !(&v[WW-2:DW-1])) return {1'b1, {(DW-1){1'b0}}};
    return v[DW-1:0];
  endfunction

  assign freq_err   = $signed({1'b0, divn}) - $signed({1'b0, fmeas});
  assign phase_raw  = tdc_vld ? tdc_out : TDC_MAX;   // late feedback reads as maximum lag
  assign brake_edge = brake & ~brake_q;
  assign fe_zero    = (freq_err == '0);
  assign fe_big     = (int'(freq_err) >= 2) || (int'(freq_err) <= -2);
  assign pe_small   = (int'(phase_raw) <= PLOCK_TOL) && (int'(phase_raw) >= -PLOCK_TOL);
  assign pe_big     = (int'(phase_raw) > ULOCK_TOL) || (int'(phase_raw) < -ULOCK_TOL);

`ifdef PLL_LF_GEARSHIFT_EN
  logic [5:0] gcnt_q, gcnt_d;
  logic       gear_on;
  assign gear_on = (gcnt_q == 6'd32);
  // Count cycles spent in PHASE_LOCKED, saturating at the gear-shift point.
  always_comb begin
    gcnt_d = '0;
    if (state_q == S_PLOCK) gcnt_d = gear_on ? gcnt_q : gcnt_q + 6'd1;
  end
  // Gear counter register.
  always_ff @(posedge refclk) begin
    if (reset) gcnt_q <= '0;
    else       gcnt_q <= gcnt_d;
  end
`endif

  // Next-state, accumulator and lock-counter logic.
  always_comb begin
    state_d     = state_q;
    acc_f_d     = acc_f_q;
    acc_p_d     = acc_p_q;
    brake_off_d = brake_off_q;
    fcnt_d      = fcnt_q;
    pcnt_d      = pcnt_q;
    ucnt_d      = ucnt_q;
    bcnt_d      = bcnt_q;
    phase_eff   = '0;
    case (state_q)
      S_UNLOCKED: begin
        if (fmeas_vld) begin
          acc_f_d = sat_acc($signed({acc_f_q[ACC_W-1], acc_f_q}) + AW1'(freq_err));
          if (!fe_zero) begin
            fcnt_d = CW'(FLOCK_CYCLES);
          end else if (fcnt_q <= CW'(1)) begin
            state_d = S_FLOCK;
            fcnt_d  = CW'(FLOCK_CYCLES);
            pcnt_d  = CW'(PLOCK_CYCLES);
          end else begin
            fcnt_d = fcnt_q - CW'(1);
          end
        end
      end
      S_FLOCK, S_PLOCK: begin
        phase_eff = phase_raw;
        acc_p_d   = sat_acc($signed({acc_p_q[ACC_W-1], acc_p_q}) + AW1'(phase_raw));
        if (state_q == S_FLOCK) begin
          if (!pe_small) begin
            pcnt_d = CW'(PLOCK_CYCLES);
          end else if (pcnt_q <= CW'(1)) begin
            state_d = S_PLOCK;
            pcnt_d  = CW'(PLOCK_CYCLES);
            ucnt_d  = CW'(ULOCK_CYCLES);
          end else begin
            pcnt_d = pcnt_q - CW'(1);
          end
        end else begin
          if (!pe_big) begin
            ucnt_d = CW'(ULOCK_CYCLES);
          end else if (ucnt_q <= CW'(1)) begin
            state_d = S_FLOCK;
            ucnt_d  = CW'(ULOCK_CYCLES);
            pcnt_d  = CW'(PLOCK_CYCLES);
          end else begin
            ucnt_d = ucnt_q - CW'(1);
          end
        end
        // A frequency jump throws the loop back to acquisition and drops the phase integral.
        if (fmeas_vld && fe_big) begin
          state_d   = S_UNLOCKED;
          acc_p_d   = '0;
          phase_eff = '0;
          fcnt_d    = CW'(FLOCK_CYCLES);
        end
      end
      S_BRAKING: begin
        if (bcnt_q <= CW'(1)) state_d = S_RECOV;
        else                  bcnt_d  = bcnt_q - CW'(1);
      end
      S_RECOV: begin
        brake_off_d = (brake_off_q > DW'(BRAKE_STEP)) ? brake_off_q - DW'(BRAKE_STEP) : '0;
        if (brake_off_d == '0) begin
          state_d = S_FLOCK;
          pcnt_d  = CW'(PLOCK_CYCLES);
        end
      end
      default: state_d = S_UNLOCKED;
    endcase
    // A brake edge overrides every other transition and freezes both integrators.
    if (brake_edge) begin
      state_d     = S_BRAKING;
      acc_f_d     = acc_f_q;
      acc_p_d     = acc_p_q;
      phase_eff   = '0;
      fcnt_d      = fcnt_q;
      pcnt_d      = pcnt_q;
      ucnt_d      = ucnt_q;
      brake_off_d = DW'(BRAKE_CODE);
      bcnt_d      = CW'(BRAKE_CYCLES);
    end
  end

  // Control-code sum from the updated accumulators.
  always_comb begin
    term_f  = WW'(acc_f_d) * WW'(KI_FREQ);
    term_p  = WW'(acc_p_d) * WW'(KI_PHASE);
    term_kp = WW'(phase_eff) * WW'(KP_PHASE);
`ifdef PLL_LF_GEARSHIFT_EN
    if (gear_on) begin
      term_p  = term_p >>> 2;
      term_kp = term_kp >>> 2;
    end
`endif
    dctrl_d = sat_dw(term_f + term_p + term_kp - WW'(brake_off_d));
  end

  // State and datapath registers.
  always_ff @(posedge refclk) begin
    if (reset) begin
      state_q     <= S_UNLOCKED;
      acc_f_q     <= '0;
      acc_p_q     <= '0;
      brake_off_q <= '0;
      dctrl_q     <= '0;
      fcnt_q      <= CW'(FLOCK_CYCLES);
      pcnt_q      <= CW'(PLOCK_CYCLES);
      ucnt_q      <= CW'(ULOCK_CYCLES);
      bcnt_q      <= CW'(BRAKE_CYCLES);
      brake_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_f_q     <= acc_f_d;
      acc_p_q     <= acc_p_d;
      brake_off_q <= brake_off_d;
      dctrl_q     <= dctrl_d;
      fcnt_q      <= fcnt_d;
      pcnt_q      <= pcnt_d;
      ucnt_q      <= ucnt_d;
      bcnt_q      <= bcnt_d;
      brake_q     <= brake;
    end
  end

  assign dctrl      = dctrl_q;
  assign lock_state = state_q;
  assign locked     = (state_q == S_PLOCK);

endmodule
